bcd_stopwatch_ctrl: RTL

//  Controller that sequences a chain of BCD decade digits as a run/pause/clear stopwatch.

---
 rtl/bcd_stopwatch_pkg.sv | 18 +
 rtl/bcd_digit.sv | 23 ++
 rtl/bcd_stopwatch_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/bcd_stopwatch_pkg.sv
// rtl/bcd_stopwatch_pkg.sv - shared types and BCD helpers for the stopwatch controller
package bcd_stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD decade; wraps 9 -> 0 on inc, flags when sitting at 9
module bcd_digit
    import bcd_stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       at_max
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= bcd_inc(q);
        end
    end

    assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// rtl/bcd_stopwatch_ctrl.sv - run/pause/clear stopwatch over a chain of BCD digits
// with a prescaled count tick and a single-slot lap snapshot register.
module bcd_stopwatch_ctrl
    import bcd_stopwatch_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int PRESCALE = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   clear,
    input  logic                   lap_req,
    input  logic                   lap_ready,
    output logic [4*NDIGITS-1:0]   count,
    output logic                   running,
    output logic                   overflow,
    output logic                   lap_valid,
    output logic [4*NDIGITS-1:0]   lap_data,
    output logic                   lap_drop
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    sw_state_t state, state_nxt;
    logic [PW-1:0] pre;
    logic tick;
    logic lap_take;
    logic [NDIGITS-1:0] at_max;
    logic [NDIGITS:0] carry;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // stop masks start even when it has nothing to do (IDLE/PAUSED)
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else if (stop) begin
            if (state == RUN) begin
                state_nxt = PAUSED;
            end
        end else if (start && (state != RUN)) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        running = (state == RUN);
    end

    // prescaler freezes on the stop cycle so a resume keeps tick phase
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pre <= '0;
        end else if ((state == RUN) && !stop) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
        end
    end

    assign tick     = (state == RUN) && !clear && !stop && (pre == PRE_LAST);
    assign carry[0] = tick;

    for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .reset  (reset),
            .clr    (clear),
            .inc    (carry[i]),
            .q      (count[4*i +: 4]),
            .at_max (at_max[i])
        );
        assign carry[i+1] = carry[i] & at_max[i];
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            overflow <= 1'b0;
        end else if (carry[NDIGITS]) begin
            overflow <= 1'b1;
        end
    end

    assign lap_take = lap_req && (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_valid <= 1'b0;
            lap_data  <= '0;
            lap_drop  <= 1'b0;
        end else begin
            lap_drop <= lap_take && lap_valid && !lap_ready;
            if (lap_take && (!lap_valid || lap_ready)) begin
                lap_data  <= count;
                lap_valid <= 1'b1;
            end else if (lap_valid && lap_ready) begin
                lap_valid <= 1'b0;
            end
        end
    end

endmodule
